sign_magnitude_accumulator: RTL and testbench
=============================================

// Module: sign_magnitude_accumulator
//
// PURPOSE
//   Streaming accumulator for N-bit sign-magnitude operands: bit N-1 is the
//   sign, bits N-2:0 are the magnitude. Sits directly downstream of the
//   combinational sign-magnitude adder stage. It takes a frame of COUNT terms
//   over a valid/ready interface, keeps a registered running sum using the
//   same add/subtract rules, and presents each frame total on a valid/ready
//   output with a sticky overflow flag.
//
// PARAMETERS
//   N      4  total operand/result width incl. sign bit (N >= 2)
//   COUNT  4  terms per frame (COUNT >= 1)
//
// PORTS
//   i_clk       in   1  single clock; all state on rising edge
//   i_rst_n     in   1  asynchronous, active-low reset
//   i_valid     in   1  input term valid
//   o_ready     out  1  block can accept a term this cycle
//   i_data      in   N  input term, sign-magnitude
//   o_valid     out  1  frame total valid
//   i_ready     in   1  downstream accepts total this cycle
//   o_data      out  N  frame total, sign-magnitude
//   o_overflow  out  1  magnitude overflowed at least once in this frame
//
// BEHAVIOUR
//   Reset (i_rst_n low, asynchronous):
//   - Outputs: o_valid=0, o_data=0, o_overflow=0, o_ready=0.
//   - Internal state: state=ACCUM, accumulator=+0, term count=0.
//   - After release, o_ready=1 on the first clock edge.
//   FSM, two states:
//   - ACCUM: o_ready=1, o_valid=0.
//     * Term accepted when i_valid&&o_ready.
//     * Each accepted term updates acc and increments cnt (width $clog2(COUNT+1)).
//     * On accepting the COUNT-th term: go to DONE, cnt<=0.
//     * o_data/o_valid are registered: the result appears 1 cycle after the
//       last term is accepted.
//   - DONE: o_ready=0; i_valid is ignored; o_valid=1.
//     * o_data and o_overflow are held stable until i_ready.
//     * On i_valid... no: on o_valid&&i_ready, go to ACCUM with acc=+0 and
//       o_overflow=0. o_valid falls and o_ready rises on the same edge.
//     * The input and output handshakes can never complete in the same cycle.
//   Arithmetic (A = acc, B = term; magnitude width M = N-1):
//   - Same sign: mag = A.mag + B.mag, computed M+1 bits wide.
//     * Carry out sets o_overflow (sticky for the frame).
//     * Magnitude wraps mod 2^M; sign = A.sign.
//   - Different sign: mag = larger magnitude - smaller magnitude.
//     * sign = sign of the larger-magnitude operand.
//     * Equal magnitudes give +0.
//   - Negative zero: input -0 (sign 1, mag 0) is treated as +0. A zero
//     magnitude result always has sign 0. o_data never shows -0.
//   - Accumulator starts each frame at +0. The first term loads the
//     normalised term.
//   Boundary cases:
//   - COUNT=1: every accepted term produces a frame.
//   - Reset mid-frame discards partial sum, count and overflow.
//   - i_data is sampled only on an accepted cycle.
//   Throughput: COUNT input cycles plus at least 1 output cycle per frame.
//
// TESTING (N=4, COUNT=4 unless stated)
//   1. Terms +3,+2,-1,+4 (0011,0010,1001,0100), no stalls
//      -> o_data=0000 (8 wraps to 0), o_overflow=1, 1 cycle after 4th accept.
//   2. Terms +5,-7,+1,-1 (0101,1111,0001,1001)
//      -> o_data=1010 (-2), o_overflow=0.
//   3. Terms +3,-3,-0,+0 (0011,1011,1000,0000)
//      -> o_data=0000 (never 1000), o_overflow=0.
//   4. Frame done, i_ready=0 for 5 cycles while i_valid=1 with junk
//      -> o_valid/o_data stable, o_ready=0, no junk accumulated;
//      i_ready=1 -> next frame starts from +0.
//   5. Two terms accepted, i_rst_n pulsed low mid-cycle -> outputs 0
//      immediately; then +1,+1,+1,+1 -> o_data=0100, o_overflow=0.
//   6. i_valid toggling 1/0 randomly against +1 terms
//      -> o_valid only after exactly 4 accepts, o_data=0100.

Source files
------------

// File: rtl/sign_magnitude_accumulator.sv
// Streaming sign-magnitude accumulator: sums COUNT terms per frame and presents
// each frame total on a valid/ready output together with a sticky overflow flag.
module sign_magnitude_accumulator #(
    parameter int N     = 4,
    parameter int COUNT = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_data,
    output logic         o_overflow
);

    localparam int M  = N - 1;
    localparam int CW = $clog2(COUNT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_DONE  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  data_q, data_d;

    logic          a_sign, b_sign, res_sign, carry;
    logic [M-1:0]  a_mag, b_mag, res_mag;
    logic [M:0]    wide_sum;
    logic [N-1:0]  sum_val;
    logic          in_fire, out_fire;

    // Adder: an input -0 is folded to +0 before the sign comparison, and a zero
    // magnitude result is always forced positive.
    always_comb begin
        a_sign   = acc_q[N-1];
        a_mag    = acc_q[M-1:0];
        b_mag    = i_data[M-1:0];
        b_sign   = i_data[N-1] & (b_mag != '0);
        wide_sum = {1'b0, a_mag} + {1'b0, b_mag};
        carry    = 1'b0;
        res_mag  = '0;
        res_sign = 1'b0;
        if (a_sign == b_sign) begin
            res_mag  = wide_sum[M-1:0];
            res_sign = a_sign;
            carry    = wide_sum[M];
        end else if (a_mag >= b_mag) begin
            res_mag  = a_mag - b_mag;
            res_sign = a_sign;
        end else begin
            res_mag  = b_mag - a_mag;
            res_sign = b_sign;
        end
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
        sum_val = {res_sign, res_mag};
    end

    assign in_fire  = (state_q == ST_ACCUM) && i_valid && ready_q;
    assign out_fire = (state_q == ST_DONE) && valid_q && i_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        ready_d = ready_q;
        valid_d = valid_q;
        data_d  = data_q;
        case (state_q)
            ST_ACCUM: begin
                ready_d = 1'b1;
                valid_d = 1'b0;
                if (in_fire) begin
                    acc_d = sum_val;
                    ovf_d = ovf_q | carry;
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        ready_d = 1'b0;
                        valid_d = 1'b1;
                        data_d  = sum_val;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                ready_d = 1'b0;
                valid_d = 1'b1;
                if (out_fire) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    ready_d = 1'b1;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_ACCUM;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
                ready_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_sign_magnitude_accumulator.sv
// Scoreboard bench for sign_magnitude_accumulator (N=4, COUNT=4) using directed
// frames with hand-computed totals.
module tb_sign_magnitude_accumulator;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_valid;
    logic       o_ready;
    logic [3:0] i_data;
    logic       o_valid;
    logic       i_ready;
    logic [3:0] o_data;
    logic       o_overflow;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [4:0] exp_q[$];
    string      name_q[$];

    sign_magnitude_accumulator #(.N(4), .COUNT(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_overflow (o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare each accepted output frame against the scoreboard head.
    initial begin
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", {3'b0, o_overflow, o_data}, 8'hff);
                end else begin
                    logic [4:0] e;
                    string      nm;
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    chk({nm, "_data"}, {4'b0, o_data}, {4'b0, e[3:0]});
                    chk({nm, "_ovf"}, {7'b0, o_overflow}, {7'b0, e[4]});
                end
            end
        end
    end

    task automatic send_term(input logic [3:0] d);
        int unsigned n;
        bit          ok;
        n  = 0;
        ok = 1'b0;
        i_valid = 1'b1;
        i_data  = d;
        while (!ok && n < 50) begin
            @(negedge i_clk);
            if (o_ready) ok = 1'b1;
            else n++;
        end
        @(posedge i_clk);
        #1;
        if (!ok) chk("accept_timeout", 8'd0, 8'd1);
        i_valid = 1'b0;
        i_data  = 4'b0110;
    endtask

    task automatic send_frame(input string nm, input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3,
                              input logic [3:0] exp_data, input logic exp_ovf);
        exp_q.push_back({exp_ovf, exp_data});
        name_q.push_back(nm);
        send_term(d0);
        send_term(d1);
        send_term(d2);
        send_term(d3);
        chk({nm, "_valid_latency"}, {7'b0, o_valid}, 8'd1);
        chk({nm, "_ready_low"}, {7'b0, o_ready}, 8'd0);
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 8'(exp_q.size()), 8'd0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_data  = 4'b0000;
        i_ready = 1'b1;
        #23;
        chk("rst_valid", {7'b0, o_valid}, 8'd0);
        chk("rst_ready", {7'b0, o_ready}, 8'd0);
        chk("rst_data", {4'b0, o_data}, 8'd0);
        chk("rst_ovf", {7'b0, o_overflow}, 8'd0);
        #2 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        chk("ready_after_rst", {7'b0, o_ready}, 8'd1);

        // 1: +3 +2 -1 +4 = 8 -> wraps to +0 with overflow
        send_frame("t1", 4'b0011, 4'b0010, 4'b1001, 4'b0100, 4'b0000, 1'b1);
        wait_drain();

        // 2: +5 -7 +1 -1 = -2
        send_frame("t2", 4'b0101, 4'b1111, 4'b0001, 4'b1001, 4'b1010, 1'b0);
        wait_drain();

        // 3: +3 -3 -0 +0 = +0
        send_frame("t3", 4'b0011, 4'b1011, 4'b1000, 4'b0000, 4'b0000, 1'b0);
        wait_drain();

        // 4: output stalled with junk offered; +1 +2 +3 +1 = +7
        i_ready = 1'b0;
        send_frame("t4", 4'b0001, 4'b0010, 4'b0011, 4'b0001, 4'b0111, 1'b0);
        i_valid = 1'b1;
        i_data  = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("t4_hold_valid", {7'b0, o_valid}, 8'd1);
            chk("t4_hold_ready", {7'b0, o_ready}, 8'd0);
            chk("t4_hold_data", {4'b0, o_data}, 8'h07);
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_drain();
        send_frame("t4_next", 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 1'b0);
        wait_drain();

        // 5: reset mid-frame after +7 +7 (which overflowed)
        send_term(4'b0111);
        send_term(4'b0111);
        #3 i_rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {7'b0, o_valid}, 8'd0);
        chk("t5_rst_ready", {7'b0, o_ready}, 8'd0);
        chk("t5_rst_data", {4'b0, o_data}, 8'd0);
        chk("t5_rst_ovf", {7'b0, o_overflow}, 8'd0);
        #2 i_rst_n = 1'b1;
        send_frame("t5", 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 1'b0);
        wait_drain();

        // 6: i_valid toggles randomly against +1 terms
        begin
            int unsigned acc;
            int unsigned n;
            acc = 0;
            n   = 0;
            exp_q.push_back(5'b0_0100);
            name_q.push_back("t6");
            i_data = 4'b0001;
            while (acc < 4 && n < 200) begin
                i_valid = 1'($urandom_range(0, 1));
                @(negedge i_clk);
                chk("t6_no_early_valid", {7'b0, o_valid}, 8'd0);
                if (i_valid && o_ready) acc++;
                @(posedge i_clk);
                #1;
                n++;
            end
            i_valid = 1'b0;
            chk("t6_accepts", 8'(acc), 8'd4);
            chk("t6_valid", {7'b0, o_valid}, 8'd1);
            wait_drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
